// File: rtl/regfile_2r1w.sv
// -----------------------------------------------------------------------------
// regfile_2r1w
//
// Purpose:
//   Parametrised register file with one synchronous write port and two
//   registered read ports. A write and a read of the same register in the
//   same cycle forward the incoming write data to the read port, so the read
//   sees the new value with no bubble. An optional hardwired-zero register
//   always reads as zero and silently drops writes.
//
// Parameters:
//   WIDTH      data bits per register
//   ADDR_BITS  address width; DEPTH = 2**ADDR_BITS
//   ZERO_EN    1: register ZERO_IDX is hardwired to zero; 0: ordinary register
//   ZERO_IDX   index of the hardwired-zero register (must be < DEPTH)
//
// Ports:
//   clk_i        rising-edge clock
//   rst_i        synchronous, active-high reset (clears storage and outputs)
//   wr_en_i      write strobe
//   wr_addr_i    write register index
//   wr_data_i    write data
//   rd_en_i      read strobe, samples both read ports together
//   rd_addr_a_i  port A read index
//   rd_addr_b_i  port B read index
//   rd_data_a_o  port A data, registered, holds while rd_en_i is low
//   rd_data_b_o  port B data, registered, holds while rd_en_i is low
//   rd_valid_o   high for one cycle after each sampled rd_en_i
// -----------------------------------------------------------------------------
module regfile_2r1w #(
  parameter int WIDTH     = 64,
  parameter int ADDR_BITS = 5,
  parameter int ZERO_EN   = 1,
  parameter int ZERO_IDX  = 31
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 wr_en_i,
  input  logic [ADDR_BITS-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]     wr_data_i,
  input  logic                 rd_en_i,
  input  logic [ADDR_BITS-1:0] rd_addr_a_i,
  input  logic [ADDR_BITS-1:0] rd_addr_b_i,
  output logic [WIDTH-1:0]     rd_data_a_o,
  output logic [WIDTH-1:0]     rd_data_b_o,
  output logic                 rd_valid_o
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [ADDR_BITS-1:0] ZeroAddr = ADDR_BITS'(ZERO_IDX);
  localparam bit ZeroOn = (ZERO_EN != 0);

  logic [WIDTH-1:0] regFile_q [DEPTH];

  logic             writeAccept;
  logic             zeroHitA;
  logic             zeroHitB;
  logic             fwdHitA;
  logic             fwdHitB;
  logic [WIDTH-1:0] rdSelA;
  logic [WIDTH-1:0] rdSelB;

  logic [WIDTH-1:0] rdDataA_q, rdDataA_d;
  logic [WIDTH-1:0] rdDataB_q, rdDataB_d;
  logic             rdValid_q, rdValid_d;

  // Writes to the hardwired-zero register are discarded here, so its storage
  // entry stays at the reset value of zero forever.
  always_comb begin
    writeAccept = wr_en_i;
    if (ZeroOn && (wr_addr_i == ZeroAddr)) begin
      writeAccept = 1'b0;
    end
  end

  // Hit detection for each read port. The zero-register hit outranks the
  // forwarding hit, so a same-cycle write aimed at the zero register can
  // never leak through the bypass path.
  always_comb begin
    zeroHitA = ZeroOn && (rd_addr_a_i == ZeroAddr);
    zeroHitB = ZeroOn && (rd_addr_b_i == ZeroAddr);
    fwdHitA  = wr_en_i && (wr_addr_i == rd_addr_a_i);
    fwdHitB  = wr_en_i && (wr_addr_i == rd_addr_b_i);
  end

  // Per-port read selection: zero register, then forwarded write data, then
  // the stored value.
  always_comb begin
    rdSelA = regFile_q[rd_addr_a_i];
    if (zeroHitA) begin
      rdSelA = '0;
    end else if (fwdHitA) begin
      rdSelA = wr_data_i;
    end
  end

  always_comb begin
    rdSelB = regFile_q[rd_addr_b_i];
    if (zeroHitB) begin
      rdSelB = '0;
    end else if (fwdHitB) begin
      rdSelB = wr_data_i;
    end
  end

  // Output next-state: the data registers only load on a read strobe and
  // otherwise hold, while valid simply tracks whether a read was sampled.
  always_comb begin
    rdDataA_d = rdDataA_q;
    rdDataB_d = rdDataB_q;
    rdValid_d = rd_en_i;
    if (rd_en_i) begin
      rdDataA_d = rdSelA;
      rdDataB_d = rdSelB;
    end
  end

  // Storage array. Reset clears every entry; otherwise only the addressed
  // entry changes on an accepted write.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        regFile_q[i] <= '0;
      end
    end else if (writeAccept) begin
      regFile_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Registered read outputs; reset wins over any read strobe.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdDataA_q <= '0;
      rdDataB_q <= '0;
      rdValid_q <= 1'b0;
    end else begin
      rdDataA_q <= rdDataA_d;
      rdDataB_q <= rdDataB_d;
      rdValid_q <= rdValid_d;
    end
  end

  assign rd_data_a_o = rdDataA_q;
  assign rd_data_b_o = rdDataB_q;
  assign rd_valid_o  = rdValid_q;

endmodule

// File: tb/tb_regfile_2r1w.sv
// -----------------------------------------------------------------------------
// tb_regfile_2r1w
//
// Three instances share one clock and reset:
//   inst0  WIDTH=64, ADDR_BITS=5, ZERO_EN=1, ZERO_IDX=31
//   inst1  WIDTH=64, ADDR_BITS=5, ZERO_EN=0
//   inst2  WIDTH=8,  ADDR_BITS=3, ZERO_EN=1, ZERO_IDX=7
// A behavioural model tracks register contents and the expected registered
// outputs of each instance; a compare process checks every cycle, and the
// directed sequence pins a set of hand-computed values.
// -----------------------------------------------------------------------------
module tb_regfile_2r1w;

  logic clk;
  logic rst;

  logic        wrEn    [3];
  logic [4:0]  wrAddr  [3];
  logic [63:0] wrData  [3];
  logic        rdEn    [3];
  logic [4:0]  rdAddrA [3];
  logic [4:0]  rdAddrB [3];

  logic [63:0] dA0, dB0, dA1, dB1;
  logic [7:0]  dA2, dB2;
  logic        v0, v1, v2;

  logic [63:0] mem  [3][32];
  logic [63:0] expA [3];
  logic [63:0] expB [3];
  logic        expV [3];
  logic        started;

  int checks;
  int passes;

  regfile_2r1w #(.WIDTH(64), .ADDR_BITS(5), .ZERO_EN(1), .ZERO_IDX(31)) u0 (
    .clk_i(clk), .rst_i(rst),
    .wr_en_i(wrEn[0]), .wr_addr_i(wrAddr[0]), .wr_data_i(wrData[0]),
    .rd_en_i(rdEn[0]), .rd_addr_a_i(rdAddrA[0]), .rd_addr_b_i(rdAddrB[0]),
    .rd_data_a_o(dA0), .rd_data_b_o(dB0), .rd_valid_o(v0)
  );

  regfile_2r1w #(.WIDTH(64), .ADDR_BITS(5), .ZERO_EN(0), .ZERO_IDX(31)) u1 (
    .clk_i(clk), .rst_i(rst),
    .wr_en_i(wrEn[1]), .wr_addr_i(wrAddr[1]), .wr_data_i(wrData[1]),
    .rd_en_i(rdEn[1]), .rd_addr_a_i(rdAddrA[1]), .rd_addr_b_i(rdAddrB[1]),
    .rd_data_a_o(dA1), .rd_data_b_o(dB1), .rd_valid_o(v1)
  );

  regfile_2r1w #(.WIDTH(8), .ADDR_BITS(3), .ZERO_EN(1), .ZERO_IDX(7)) u2 (
    .clk_i(clk), .rst_i(rst),
    .wr_en_i(wrEn[2]), .wr_addr_i(wrAddr[2][2:0]), .wr_data_i(wrData[2][7:0]),
    .rd_en_i(rdEn[2]), .rd_addr_a_i(rdAddrA[2][2:0]), .rd_addr_b_i(rdAddrB[2][2:0]),
    .rd_data_a_o(dA2), .rd_data_b_o(dB2), .rd_valid_o(v2)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-instance shape: address mask, data mask, and which index reads zero.
  function automatic logic [4:0] addrMask(int k);
    return (k == 2) ? 5'h07 : 5'h1F;
  endfunction

  function automatic logic [63:0] dataMask(int k);
    return (k == 2) ? 64'hFF : {64{1'b1}};
  endfunction

  function automatic bit isZeroReg(int k, logic [4:0] a);
    if (k == 0) return a == 5'd31;
    if (k == 2) return a == 5'd7;
    return 1'b0;
  endfunction

  // What a read of address a on instance k must return this cycle.
  function automatic logic [63:0] modelRead(int k, logic [4:0] aIn);
    logic [4:0] a;
    a = aIn & addrMask(k);
    if (isZeroReg(k, a)) return 64'h0;
    if (wrEn[k] && ((wrAddr[k] & addrMask(k)) == a)) return wrData[k] & dataMask(k);
    return mem[k][a];
  endfunction

  // Reference model: updated on every rising edge from the sampled inputs.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        for (int i = 0; i < 32; i++) mem[k][i] <= 64'h0;
        expA[k] <= 64'h0;
        expB[k] <= 64'h0;
        expV[k] <= 1'b0;
      end else begin
        if (rdEn[k]) begin
          expA[k] <= modelRead(k, rdAddrA[k]);
          expB[k] <= modelRead(k, rdAddrB[k]);
        end
        expV[k] <= rdEn[k];
        if (wrEn[k] && !isZeroReg(k, wrAddr[k] & addrMask(k)))
          mem[k][wrAddr[k] & addrMask(k)] <= wrData[k] & dataMask(k);
      end
    end
    if (rst) started <= 1'b1;
  end

  function automatic logic [63:0] actA(int k);
    case (k)
      0: return dA0;
      1: return dA1;
      default: return {56'h0, dA2};
    endcase
  endfunction

  function automatic logic [63:0] actB(int k);
    case (k)
      0: return dB0;
      1: return dB1;
      default: return {56'h0, dB2};
    endcase
  endfunction

  function automatic logic actV(int k);
    case (k)
      0: return v0;
      1: return v1;
      default: return v2;
    endcase
  endfunction

  task automatic compareOne(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Every-cycle comparison of all three instances against the model.
  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 3; k++) begin
        compareOne($sformatf("model inst%0d rdA t=%0t", k, $time), actA(k), expA[k]);
        compareOne($sformatf("model inst%0d rdB t=%0t", k, $time), actB(k), expB[k]);
        compareOne($sformatf("model inst%0d valid t=%0t", k, $time),
                   {63'h0, actV(k)}, {63'h0, expV[k]});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of stimulus on instance k, then drop its strobes.
  task automatic applyStimulus(int k, bit we, int wa, logic [63:0] wd,
                               bit re, int ra, int rb);
    wrEn[k]    = we;
    wrAddr[k]  = wa[4:0];
    wrData[k]  = wd;
    rdEn[k]    = re;
    rdAddrA[k] = ra[4:0];
    rdAddrB[k] = rb[4:0];
    tick();
    wrEn[k] = 1'b0;
    rdEn[k] = 1'b0;
  endtask

  // Hand-computed literal expectations, sampled just after a rising edge.
  task automatic checkOutput(string name, int k, logic [63:0] eA,
                             logic [63:0] eB, logic eV);
    compareOne({name, " rdA"}, actA(k), eA);
    compareOne({name, " rdB"}, actB(k), eB);
    compareOne({name, " valid"}, {63'h0, actV(k)}, {63'h0, eV});
  endtask

  initial begin
    checks  = 0;
    passes  = 0;
    started = 1'b0;
    rst     = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wrEn[k] = 1'b0; wrAddr[k] = '0; wrData[k] = '0;
      rdEn[k] = 1'b0; rdAddrA[k] = '0; rdAddrB[k] = '0;
    end
    tick();
    tick();
    rst = 1'b0;
    checkOutput("after reset", 0, 64'h0, 64'h0, 1'b0);

    // Reset clears a written register; reset dominates a concurrent read.
    applyStimulus(0, 1'b1, 3, 64'hAA, 1'b0, 0, 0);
    rst = 1'b1;
    applyStimulus(0, 1'b0, 0, 64'h0, 1'b1, 3, 3);
    rst = 1'b0;
    checkOutput("reset dominates", 0, 64'h0, 64'h0, 1'b0);
    applyStimulus(0, 1'b0, 0, 64'h0, 1'b1, 3, 3);
    checkOutput("r3 cleared", 0, 64'h0, 64'h0, 1'b1);

    // Write then read.
    applyStimulus(0, 1'b1, 5, 64'h1234, 1'b0, 0, 0);
    applyStimulus(0, 1'b0, 0, 64'h0, 1'b1, 5, 0);
    checkOutput("write then read", 0, 64'h1234, 64'h0, 1'b1);

    // Forwarding, then the written value persists.
    applyStimulus(0, 1'b1, 7, 64'hDEAD, 1'b1, 7, 7);
    checkOutput("forwarding", 0, 64'hDEAD, 64'hDEAD, 1'b1);
    applyStimulus(0, 1'b0, 0, 64'h0, 1'b1, 7, 7);
    checkOutput("r7 persists", 0, 64'hDEAD, 64'hDEAD, 1'b1);

    // Zero register on inst0, ordinary register on inst1.
    applyStimulus(0, 1'b1, 31, 64'hFFFF, 1'b1, 31, 5);
    checkOutput("zero reg same cycle", 0, 64'h0, 64'h1234, 1'b1);
    applyStimulus(0, 1'b0, 0, 64'h0, 1'b1, 31, 31);
    checkOutput("zero reg later", 0, 64'h0, 64'h0, 1'b1);
    applyStimulus(1, 1'b1, 31, 64'hFFFF, 1'b1, 31, 31);
    checkOutput("no zero same cycle", 1, 64'hFFFF, 64'hFFFF, 1'b1);
    applyStimulus(1, 1'b0, 0, 64'h0, 1'b1, 31, 31);
    checkOutput("no zero later", 1, 64'hFFFF, 64'hFFFF, 1'b1);

    // Back-to-back reads, then hold while rd_en is low (even across a write).
    applyStimulus(0, 1'b0, 0, 64'h0, 1'b1, 5, 7);
    checkOutput("pulse 1", 0, 64'h1234, 64'hDEAD, 1'b1);
    applyStimulus(0, 1'b0, 0, 64'h0, 1'b1, 7, 5);
    checkOutput("pulse 2", 0, 64'hDEAD, 64'h1234, 1'b1);
    applyStimulus(0, 1'b0, 0, 64'h0, 1'b0, 3, 3);
    checkOutput("hold 1", 0, 64'hDEAD, 64'h1234, 1'b0);
    applyStimulus(0, 1'b1, 7, 64'hBEEF, 1'b0, 7, 7);
    checkOutput("hold 2", 0, 64'hDEAD, 64'h1234, 1'b0);

    // Narrow instance sweep: r7 is the zero register, its write is dropped.
    for (int i = 0; i < 8; i++) applyStimulus(2, 1'b1, i, 64'(i * 17), 1'b0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(2, 1'b0, 0, 64'h0, 1'b1, i, 7 - i);
      checkOutput($sformatf("sweep %0d", i), 2,
                  (i == 7) ? 64'h0 : 64'(i * 17),
                  (i == 0) ? 64'h0 : 64'((7 - i) * 17), 1'b1);
    end

    // Mixed traffic on inst0, checked by the model every cycle.
    for (int n = 0; n < 40; n++) begin
      applyStimulus(0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 31)),
                    {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
    end
    tick();
    tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
